// File: rtl/dual_pkg.sv
// Shared constants for the dual-port FIFO and its memory blocks.
// Default widths, depth and occupancy thresholds.
package dual_pkg;

    localparam int def_wi    = 8;
    localparam int def_dep   = 16;
    localparam int def_add   = 4;
    localparam int def_af_th = 12;
    localparam int def_ae_th = 4;

endpackage

// File: rtl/dual_ram_sync.sv
// Single-clock simple dual-port RAM, dep x wi.
// Synchronous write port, registered read port with enable.
module dual_ram_sync
    import dual_pkg::*;
#(
    parameter int wi  = def_wi,
    parameter int dep = def_dep,
    parameter int add = def_add
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           we,
    input  logic [add-1:0] waddr,
    input  logic [wi-1:0]  wdata,
    input  logic           re,
    input  logic [add-1:0] raddr,
    output logic [wi-1:0]  rdata
);

    logic [wi-1:0] mem [dep];

    // Write port; the array is never cleared.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read register; same-address write returns the old word.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/dual_fifo_sync.sv
// Synchronous FIFO with registered flags and overflow/underflow pulses.
// Pointer, count and flag logic around a dual-port RAM.
module dual_fifo_sync
    import dual_pkg::*;
#(
    parameter int wi    = def_wi,
    parameter int dep   = def_dep,
    parameter int add   = def_add,
    parameter int af_th = def_af_th,
    parameter int ae_th = def_ae_th
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr,
    input  logic          rd,
    input  logic [wi-1:0] din,
    output logic [wi-1:0] dout,
    output logic          full,
    output logic          empty,
    output logic          afull,
    output logic          aempty,
    output logic [add:0]  cnt,
    output logic          ovf,
    output logic          udf
);

    logic [add-1:0] wp;
    logic [add-1:0] rp;
    logic [add:0]   cnt_n;
    logic           rd_ok;
    logic           wr_ok;

    // Accept decisions and next occupancy.
    always_comb begin
        rd_ok = rd & ~empty;
        wr_ok = wr & (~full | rd_ok);
        cnt_n = cnt;
        if (wr_ok & ~rd_ok) begin
            cnt_n = cnt + (add+1)'(1);
        end else if (rd_ok & ~wr_ok) begin
            cnt_n = cnt - (add+1)'(1);
        end
    end

    // Pointers, count, flags and error pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            wp     <= '0;
            rp     <= '0;
            cnt    <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
            afull  <= 1'b0;
            aempty <= 1'b1;
            ovf    <= 1'b0;
            udf    <= 1'b0;
        end else begin
            if (wr_ok) begin
                wp <= wp + add'(1);
            end
            if (rd_ok) begin
                rp <= rp + add'(1);
            end
            cnt    <= cnt_n;
            full   <= (cnt_n == (add+1)'(dep));
            empty  <= (cnt_n == '0);
            afull  <= (cnt_n >= (add+1)'(af_th));
            aempty <= (cnt_n <= (add+1)'(ae_th));
            ovf    <= wr & ~wr_ok;
            udf    <= rd & empty;
        end
    end

    dual_ram_sync #(
        .wi  (wi),
        .dep (dep),
        .add (add)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (wr_ok & ~rst),
        .waddr (wp),
        .wdata (din),
        .re    (rd_ok & ~rst),
        .raddr (rp),
        .rdata (dout)
    );

endmodule
